rtc_scandriver: RTL

Parametrised, time-multiplexed 7-segment driver for the stopwatch/RTC display. Takes a packed-BCD count, captures it into a tear-free frame buffer on request, and scans one digit at a time onto a shared segment bus with one-hot digit enables. Adds leading-zero blanking, per-digit decimal points and 16-level brightness control. Sits between the stopwatch counter and the board's common-anode display pins.

---
 rtl/rtc_disp_pkg.sv | 20 ++
 rtl/rtc_bcd7seg.sv | 32 +++
 rtl/rtc_scandriver.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/rtc_disp_pkg.sv
// Shared constants for the RTC/stopwatch 7-segment display path.
// Glyph patterns are active-high {dp,g,f,e,d,c,b,a}.
package rtc_disp_pkg;

  localparam int MAX_DIGITS = 8;

  localparam logic [7:0] SEG_0    = 8'h3F;
  localparam logic [7:0] SEG_1    = 8'h06;
  localparam logic [7:0] SEG_2    = 8'h5B;
  localparam logic [7:0] SEG_3    = 8'h4F;
  localparam logic [7:0] SEG_4    = 8'h66;
  localparam logic [7:0] SEG_5    = 8'h6D;
  localparam logic [7:0] SEG_6    = 8'h7D;
  localparam logic [7:0] SEG_7    = 8'h07;
  localparam logic [7:0] SEG_8    = 8'h7F;
  localparam logic [7:0] SEG_9    = 8'h6F;
  localparam logic [7:0] SEG_DASH = 8'h40;
  localparam logic [7:0] SEG_OFF  = 8'h00;

endpackage

// File: rtl/rtc_bcd7seg.sv
// Combinational BCD nibble + decimal point to active-high segment pattern.
// Non-BCD codes render as a dash so corrupt counts are visible on the display.
module rtc_bcd7seg
  import rtc_disp_pkg::*;
(
  input  logic [3:0] i_nib,
  input  logic       i_dp,
  output logic [7:0] o_seg
);

  logic [7:0] glyph;

  always_comb begin
    glyph = SEG_DASH;
    unique case (i_nib)
      4'd0:    glyph = SEG_0;
      4'd1:    glyph = SEG_1;
      4'd2:    glyph = SEG_2;
      4'd3:    glyph = SEG_3;
      4'd4:    glyph = SEG_4;
      4'd5:    glyph = SEG_5;
      4'd6:    glyph = SEG_6;
      4'd7:    glyph = SEG_7;
      4'd8:    glyph = SEG_8;
      4'd9:    glyph = SEG_9;
      default: glyph = SEG_DASH;
    endcase
  end

  assign o_seg = {i_dp, glyph[6:0]};

endmodule

// File: rtl/rtc_scandriver.sv
// Time-multiplexed 7-segment scan driver with tear-free frame buffering,
// leading-zero blanking and PWM brightness on the digit enables.
module rtc_scandriver
  import rtc_disp_pkg::*;
#(
  parameter int NUM_DIGITS     = 6,
  parameter int SCAN_DIV       = 1000,
  parameter int ACTIVE_LOW_SEG = 1,
  parameter int ACTIVE_LOW_AN  = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [4*NUM_DIGITS-1:0] i_count,
  input  logic [NUM_DIGITS-1:0]   i_dp,
  input  logic                    i_load,
  input  logic                    i_blank_lz,
  input  logic [3:0]              i_bright,
  output logic [7:0]              o_segout,
  output logic [NUM_DIGITS-1:0]   o_anode,
  output logic                    o_frame
);

  localparam int SC_W  = $clog2(SCAN_DIV);
  localparam int DIG_W = $clog2(NUM_DIGITS);
  localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(SCAN_DIV - 1);
  localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(NUM_DIGITS - 1);
  localparam logic [7:0] SEG_OFF_PIN = (ACTIVE_LOW_SEG != 0) ? 8'hFF : SEG_OFF;
  localparam logic [NUM_DIGITS-1:0] AN_OFF_PIN =
    (ACTIVE_LOW_AN != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  logic [SC_W-1:0]         sc_q, sc_d;
  logic [DIG_W-1:0]        dig_q, dig_d;
  logic [4*NUM_DIGITS-1:0] pend_cnt_q, pend_cnt_d, shd_cnt_q, shd_cnt_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d, shd_dp_q, shd_dp_d;
  logic                    pend_vld_q, pend_vld_d;
  logic [7:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    frame_q, frame_d;

  logic                  boundary;
  logic [NUM_DIGITS-1:0] blank;
  logic                  leading;
  logic [3:0]            cur_nib;
  logic [7:0]            glyph_seg;
  logic [31:0]           on_len;
  logic                  lit;
  logic [7:0]            seg_act;
  logic [NUM_DIGITS-1:0] an_act;

  assign boundary = (dig_q == DIG_LAST) && (sc_q == SC_LAST);

  always_comb begin
    sc_d       = (sc_q == SC_LAST) ? '0 : sc_q + 1'b1;
    dig_d      = dig_q;
    if (sc_q == SC_LAST) dig_d = (dig_q == DIG_LAST) ? '0 : dig_q + 1'b1;

    pend_cnt_d = pend_cnt_q;
    pend_dp_d  = pend_dp_q;
    pend_vld_d = pend_vld_q;
    shd_cnt_d  = shd_cnt_q;
    shd_dp_d   = shd_dp_q;
    if (i_load) begin
      pend_cnt_d = i_count;
      pend_dp_d  = i_dp;
      pend_vld_d = 1'b1;
    end
    // A load coinciding with the boundary bypasses pending straight into the shadow.
    if (boundary) begin
      pend_vld_d = 1'b0;
      if (i_load) begin
        shd_cnt_d = i_count;
        shd_dp_d  = i_dp;
      end else if (pend_vld_q) begin
        shd_cnt_d = pend_cnt_q;
        shd_dp_d  = pend_dp_q;
      end
    end
  end

  always_comb begin
    blank   = '0;
    leading = i_blank_lz;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      if (leading && (shd_cnt_q[4*k +: 4] == 4'd0) && !shd_dp_q[k]) blank[k] = 1'b1;
      else leading = 1'b0;
    end
  end

  assign cur_nib = shd_cnt_q[{dig_q, 2'b00} +: 4];

  rtc_bcd7seg u_bcd7seg (
    .i_nib (cur_nib),
    .i_dp  (shd_dp_q[dig_q]),
    .o_seg (glyph_seg)
  );

  // sc = 0 stays dark so the previous digit's enable never overlaps the new segments.
  always_comb begin
    on_len = ((32'(i_bright) + 32'd1) * 32'(SCAN_DIV)) >> 4;
    if (on_len > 32'(SCAN_DIV - 1)) on_len = 32'(SCAN_DIV - 1);
    lit     = (sc_q != '0) && (32'(sc_q) <= on_len);
    seg_act = blank[dig_q] ? SEG_OFF : glyph_seg;
    an_act  = '0;
    if (lit) an_act[dig_q] = 1'b1;
    seg_d   = (ACTIVE_LOW_SEG != 0) ? ~seg_act : seg_act;
    an_d    = (ACTIVE_LOW_AN != 0) ? ~an_act : an_act;
    frame_d = (dig_q == '0) && (sc_q == '0);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sc_q       <= '0;
      dig_q      <= '0;
      pend_cnt_q <= '0;
      pend_dp_q  <= '0;
      pend_vld_q <= 1'b0;
      shd_cnt_q  <= '0;
      shd_dp_q   <= '0;
      seg_q      <= SEG_OFF_PIN;
      an_q       <= AN_OFF_PIN;
      frame_q    <= 1'b0;
    end else begin
      sc_q       <= sc_d;
      dig_q      <= dig_d;
      pend_cnt_q <= pend_cnt_d;
      pend_dp_q  <= pend_dp_d;
      pend_vld_q <= pend_vld_d;
      shd_cnt_q  <= shd_cnt_d;
      shd_dp_q   <= shd_dp_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
      frame_q    <= frame_d;
    end
  end

  assign o_segout = seg_q;
  assign o_anode  = an_q;
  assign o_frame  = frame_q;

endmodule
